// File: rtl/axi_lite_xbar_if.sv
// AXI-lite bundle (32-bit address, 64-bit data) shared by the crossbar's
// master-facing and slave-facing ports.
interface axi_lite_xbar_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_xbar.sv
// 1-to-2 AXI-lite crossbar with a single transaction in flight; addresses
// outside both windows complete locally with DECERR.
module axi_lite_xbar #(
    parameter logic [31:0] MEM_BASE = 32'h8000_0000,
    parameter logic [31:0] MEM_MASK = 32'hF000_0000,
    parameter logic [31:0] DEV_BASE = 32'hA000_0000,
    parameter logic [31:0] DEV_MASK = 32'hF000_0000
) (
    input  logic           clk,
    input  logic           rst,
    axi_lite_xbar_if.slave  m,
    axi_lite_xbar_if.master s0,
    axi_lite_xbar_if.master s1
);

    typedef enum logic [2:0] {IDLE, RD, WR, RD_ERR, WR_ERR_W, WR_ERR_B} state_t;
    typedef enum logic [1:0] {DEC_MEM, DEC_DEV, DEC_ERR} dec_t;

    // Memory window takes priority when the two windows overlap.
    function automatic dec_t decode(input logic [31:0] a);
        if ((a & MEM_MASK) == MEM_BASE)      return DEC_MEM;
        else if ((a & DEV_MASK) == DEV_BASE) return DEC_DEV;
        else                                 return DEC_ERR;
    endfunction

    state_t      state;
    logic        tgt;
    logic [31:0] addr_q;
    logic        pend;
    dec_t        ar_dec;
    dec_t        aw_dec;
    logic        sel_arready;
    logic        sel_awready;

    assign ar_dec      = decode(m.araddr);
    assign aw_dec      = decode(m.awaddr);
    assign sel_arready = tgt ? s1.arready : s0.arready;
    assign sel_awready = tgt ? s1.awready : s0.awready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            tgt    <= 1'b0;
            addr_q <= '0;
            pend   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m.arvalid) begin
                        addr_q <= m.araddr;
                        tgt    <= (ar_dec == DEC_DEV);
                        pend   <= (ar_dec != DEC_ERR);
                        state  <= (ar_dec == DEC_ERR) ? RD_ERR : RD;
                    end else if (m.awvalid) begin
                        addr_q <= m.awaddr;
                        tgt    <= (aw_dec == DEC_DEV);
                        pend   <= (aw_dec != DEC_ERR);
                        state  <= (aw_dec == DEC_ERR) ? WR_ERR_W : WR;
                    end
                end
                RD: begin
                    if (pend && sel_arready) pend <= 1'b0;
                    if (m.rvalid && m.rready) state <= IDLE;
                end
                WR: begin
                    if (pend && sel_awready) pend <= 1'b0;
                    if (m.bvalid && m.bready) state <= IDLE;
                end
                RD_ERR:   if (m.rready) state <= IDLE;
                WR_ERR_W: if (m.wvalid) state <= WR_ERR_B;
                WR_ERR_B: if (m.bready) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m.arready  = 1'b0;
        m.awready  = 1'b0;
        m.rdata    = '0;
        m.rresp    = '0;
        m.rvalid   = 1'b0;
        m.wready   = 1'b0;
        m.bresp    = '0;
        m.bvalid   = 1'b0;
        s0.araddr  = '0;  s1.araddr  = '0;
        s0.arvalid = 1'b0; s1.arvalid = 1'b0;
        s0.rready  = 1'b0; s1.rready  = 1'b0;
        s0.awaddr  = '0;  s1.awaddr  = '0;
        s0.awvalid = 1'b0; s1.awvalid = 1'b0;
        s0.wdata   = '0;  s1.wdata   = '0;
        s0.wstrb   = '0;  s1.wstrb   = '0;
        s0.wvalid  = 1'b0; s1.wvalid  = 1'b0;
        s0.bready  = 1'b0; s1.bready  = 1'b0;
        case (state)
            // Ready is held low while reset is asserted even though state is IDLE.
            IDLE: begin
                m.arready = rst;
                m.awready = rst & ~m.arvalid;
            end
            RD: begin
                if (!tgt) begin
                    s0.araddr  = addr_q;
                    s0.arvalid = pend;
                    s0.rready  = m.rready;
                    m.rdata    = s0.rdata;
                    m.rresp    = s0.rresp;
                    m.rvalid   = s0.rvalid;
                end else begin
                    s1.araddr  = addr_q;
                    s1.arvalid = pend;
                    s1.rready  = m.rready;
                    m.rdata    = s1.rdata;
                    m.rresp    = s1.rresp;
                    m.rvalid   = s1.rvalid;
                end
            end
            // W is a straight wire so data may complete before the slave takes AW.
            WR: begin
                if (!tgt) begin
                    s0.awaddr  = addr_q;
                    s0.awvalid = pend;
                    s0.wdata   = m.wdata;
                    s0.wstrb   = m.wstrb;
                    s0.wvalid  = m.wvalid;
                    s0.bready  = m.bready;
                    m.wready   = s0.wready;
                    m.bresp    = s0.bresp;
                    m.bvalid   = s0.bvalid;
                end else begin
                    s1.awaddr  = addr_q;
                    s1.awvalid = pend;
                    s1.wdata   = m.wdata;
                    s1.wstrb   = m.wstrb;
                    s1.wvalid  = m.wvalid;
                    s1.bready  = m.bready;
                    m.wready   = s1.wready;
                    m.bresp    = s1.bresp;
                    m.bvalid   = s1.bvalid;
                end
            end
            RD_ERR: begin
                m.rvalid = 1'b1;
                m.rresp  = 2'b11;
            end
            WR_ERR_W: m.wready = 1'b1;
            WR_ERR_B: begin
                m.bvalid = 1'b1;
                m.bresp  = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_xbar.sv
// Directed bench for axi_lite_xbar: decode, arbitration, stalls, DECERR and reset abort.
module tb_axi_lite_xbar;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   r_hs;
    int   s0_act;
    int   s1_act;

    axi_lite_xbar_if m_if ();
    axi_lite_xbar_if s0_if ();
    axi_lite_xbar_if s1_if ();

    axi_lite_xbar dut (
        .clk (clk),
        .rst (rst),
        .m   (m_if),
        .s0  (s0_if),
        .s1  (s1_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_if.rvalid && m_if.rready) r_hs++;
        if (s0_if.arvalid || s0_if.awvalid || s0_if.wvalid) s0_act++;
        if (s1_if.arvalid || s1_if.awvalid || s1_if.wvalid) s1_act++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait read from slave 0 with the full 3-cycle latency checked.
    task automatic do_read(input logic [31:0] a, input logic [63:0] d);
        int s1_base;
        s1_base = s1_act;
        m_if.araddr = a; m_if.arvalid = 1'b1; s0_if.arready = 1'b1;
        #1 chk("rd_arready", m_if.arready, 1);
        cyc();
        m_if.arvalid = 1'b0; m_if.araddr = '0;
        #1;
        chk("rd_s0_arvalid", s0_if.arvalid, 1);
        chk("rd_s0_araddr", s0_if.araddr, a);
        chk("rd_s1_araddr", s1_if.araddr, 0);
        chk("rd_busy_arready", m_if.arready, 0);
        cyc();
        chk("rd_s0_ar_done", s0_if.arvalid, 0);
        s0_if.rvalid = 1'b1; s0_if.rdata = d; s0_if.rresp = 2'b00; m_if.rready = 1'b1;
        #1;
        chk("rd_rvalid", m_if.rvalid, 1);
        chk("rd_rdata", m_if.rdata, d);
        chk("rd_rresp", m_if.rresp, 0);
        chk("rd_s0_rready", s0_if.rready, 1);
        chk("rd_s1_rready", s1_if.rready, 0);
        cyc();
        s0_if.rvalid = 1'b0; s0_if.rdata = '0; m_if.rready = 1'b0; s0_if.arready = 1'b0;
        #1;
        chk("rd_idle_arready", m_if.arready, 1);
        chk("rd_idle_rvalid", m_if.rvalid, 0);
        chk("rd_s1_untouched", s1_act - s1_base, 0);
    endtask

    initial begin
        int s0_base;
        int s1_base;
        int hs_base;
        n_vec = 0; n_err = 0; r_hs = 0; s0_act = 0; s1_act = 0;
        rst = 1'b0;
        m_if.araddr = '0; m_if.arvalid = 1'b0; m_if.rready = 1'b0;
        m_if.awaddr = '0; m_if.awvalid = 1'b0; m_if.wdata = '0; m_if.wstrb = '0;
        m_if.wvalid = 1'b0; m_if.bready = 1'b0;
        s0_if.arready = 1'b0; s0_if.rdata = '0; s0_if.rresp = '0; s0_if.rvalid = 1'b0;
        s0_if.awready = 1'b0; s0_if.wready = 1'b0; s0_if.bresp = '0; s0_if.bvalid = 1'b0;
        s1_if.arready = 1'b0; s1_if.rdata = '0; s1_if.rresp = '0; s1_if.rvalid = 1'b0;
        s1_if.awready = 1'b0; s1_if.wready = 1'b0; s1_if.bresp = '0; s1_if.bvalid = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_rvalid", m_if.rvalid, 0);
        chk("rst_bvalid", m_if.bvalid, 0);
        chk("rst_wready", m_if.wready, 0);
        chk("rst_s0_arvalid", s0_if.arvalid, 0);
        chk("rst_s1_awvalid", s1_if.awvalid, 0);
        rst = 1'b1;
        #1;
        chk("rel_arready", m_if.arready, 1);
        chk("rel_awready", m_if.awready, 1);

        // Read hitting memory
        cyc();
        do_read(32'h8000_0010, 64'h1122_3344_5566_7788);

        // Write hitting devices, W offered together with AW
        s0_base = s0_act;
        m_if.awaddr = 32'hA000_03F8; m_if.awvalid = 1'b1;
        m_if.wdata = 64'h41; m_if.wstrb = 8'h01; m_if.wvalid = 1'b1;
        #1;
        chk("wr_awready", m_if.awready, 1);
        chk("wr_idle_wready", m_if.wready, 0);
        cyc();
        m_if.awvalid = 1'b0; s1_if.awready = 1'b1; s1_if.wready = 1'b1;
        #1;
        chk("wr_s1_awvalid", s1_if.awvalid, 1);
        chk("wr_s1_awaddr", s1_if.awaddr, 32'hA000_03F8);
        chk("wr_s1_wdata", s1_if.wdata, 64'h41);
        chk("wr_s1_wstrb", s1_if.wstrb, 8'h01);
        chk("wr_s1_wvalid", s1_if.wvalid, 1);
        chk("wr_m_wready", m_if.wready, 1);
        chk("wr_s0_awaddr", s0_if.awaddr, 0);
        cyc();
        m_if.wvalid = 1'b0; m_if.wdata = '0; m_if.wstrb = '0;
        s1_if.awready = 1'b0; s1_if.wready = 1'b0;
        s1_if.bvalid = 1'b1; s1_if.bresp = 2'b00; m_if.bready = 1'b1;
        #1;
        chk("wr_aw_done", s1_if.awvalid, 0);
        chk("wr_bvalid", m_if.bvalid, 1);
        chk("wr_bresp", m_if.bresp, 0);
        chk("wr_s1_bready", s1_if.bready, 1);
        cyc();
        s1_if.bvalid = 1'b0; m_if.bready = 1'b0;
        #1;
        chk("wr_idle_bvalid", m_if.bvalid, 0);
        chk("wr_s0_untouched", s0_act - s0_base, 0);

        // Read decode error, held for a cycle with rready low
        s0_base = s0_act; s1_base = s1_act;
        m_if.araddr = 32'h1000_0000; m_if.arvalid = 1'b1;
        cyc();
        m_if.arvalid = 1'b0; m_if.araddr = '0;
        #1;
        chk("rderr_rvalid", m_if.rvalid, 1);
        chk("rderr_rresp", m_if.rresp, 2'b11);
        chk("rderr_rdata", m_if.rdata, 0);
        cyc();
        chk("rderr_hold", m_if.rvalid, 1);
        m_if.rready = 1'b1;
        cyc();
        m_if.rready = 1'b0;
        #1;
        chk("rderr_done", m_if.rvalid, 0);
        chk("rderr_s0_quiet", s0_act - s0_base, 0);
        chk("rderr_s1_quiet", s1_act - s1_base, 0);

        // Write decode error
        m_if.awaddr = 32'h2000_0000; m_if.awvalid = 1'b1;
        cyc();
        m_if.awvalid = 1'b0; m_if.wdata = 64'hFFFF; m_if.wvalid = 1'b1;
        #1;
        chk("wrerr_wready", m_if.wready, 1);
        cyc();
        m_if.wvalid = 1'b0;
        #1;
        chk("wrerr_bvalid", m_if.bvalid, 1);
        chk("wrerr_bresp", m_if.bresp, 2'b11);
        m_if.bready = 1'b1;
        cyc();
        m_if.bready = 1'b0;
        #1;
        chk("wrerr_done", m_if.bvalid, 0);
        chk("wrerr_slaves_quiet", (s0_act - s0_base) + (s1_act - s1_base), 0);

        // Simultaneous AR and AW: read first, write after the IDLE cycle
        m_if.araddr = 32'h8000_0020; m_if.arvalid = 1'b1;
        m_if.awaddr = 32'h8000_0030; m_if.awvalid = 1'b1;
        #1;
        chk("arb_arready", m_if.arready, 1);
        chk("arb_awready", m_if.awready, 0);
        cyc();
        m_if.arvalid = 1'b0; s0_if.arready = 1'b1;
        #1;
        chk("arb_rd_first", s0_if.araddr, 32'h8000_0020);
        chk("arb_no_aw", s0_if.awvalid, 0);
        cyc();
        s0_if.arready = 1'b0; s0_if.rvalid = 1'b1; s0_if.rdata = 64'h5; m_if.rready = 1'b1;
        cyc();
        s0_if.rvalid = 1'b0; m_if.rready = 1'b0;
        #1;
        chk("arb_idle_awready", m_if.awready, 1);
        cyc();
        m_if.awvalid = 1'b0;
        #1;
        chk("arb_wr_awvalid", s0_if.awvalid, 1);
        chk("arb_wr_awaddr", s0_if.awaddr, 32'h8000_0030);
        s0_if.awready = 1'b1; s0_if.wready = 1'b1; m_if.wvalid = 1'b1; m_if.wdata = 64'h77;
        cyc();
        s0_if.awready = 1'b0; s0_if.wready = 1'b0; m_if.wvalid = 1'b0;
        s0_if.bvalid = 1'b1; m_if.bready = 1'b1;
        cyc();
        s0_if.bvalid = 1'b0; m_if.bready = 1'b0;
        #1;
        chk("arb_wr_done", m_if.awready, 1);

        // Slave 0 stalls AR for 5 cycles, then R is back-pressured for 3
        m_if.araddr = 32'h8000_0040; m_if.arvalid = 1'b1;
        cyc();
        m_if.arvalid = 1'b0; m_if.araddr = '0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_arvalid", s0_if.arvalid, 1);
            chk("stall_araddr", s0_if.araddr, 32'h8000_0040);
            cyc();
        end
        s0_if.arready = 1'b1;
        cyc();
        s0_if.arready = 1'b0;
        s0_if.rvalid = 1'b1; s0_if.rdata = 64'hCAFE_F00D_0000_0001;
        hs_base = r_hs;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rvalid", m_if.rvalid, 1);
            chk("bp_rdata", m_if.rdata, 64'hCAFE_F00D_0000_0001);
            chk("bp_s0_rready", s0_if.rready, 0);
            cyc();
        end
        m_if.rready = 1'b1;
        cyc();
        s0_if.rvalid = 1'b0; m_if.rready = 1'b0;
        cyc();
        chk("bp_one_r_handshake", r_hs - hs_base, 1);

        // Reset asserted while in RD
        m_if.araddr = 32'h8000_0050; m_if.arvalid = 1'b1;
        cyc();
        m_if.arvalid = 1'b0; m_if.araddr = '0; s0_if.rvalid = 1'b1;
        #1;
        chk("abort_pre_arvalid", s0_if.arvalid, 1);
        rst = 1'b0;
        #1;
        chk("abort_s0_arvalid", s0_if.arvalid, 0);
        chk("abort_rvalid", m_if.rvalid, 0);
        cyc();
        s0_if.rvalid = 1'b0;
        chk("abort_hold_arvalid", s0_if.arvalid, 0);
        rst = 1'b1;
        cyc();
        do_read(32'h8000_0058, 64'hDEAD_BEEF_0123_4567);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_xbar.md
AXI_LITE_XBAR -- requirements
Module: axi_lite_xbar

Interface
- REQ-001: Parameter MEM_BASE, default 32'h8000_0000, base address of slave 0 (memory).
- REQ-002: Parameter MEM_MASK, default 32'hF000_0000, decode mask for slave 0.
- REQ-003: Parameter DEV_BASE, default 32'hA000_0000, base address of slave 1 (devices).
- REQ-004: Parameter DEV_MASK, default 32'hF000_0000, decode mask for slave 1.
- REQ-005: clk  in  1  sole clock; all state changes on its rising edge.
- REQ-006: rst  in  1  asynchronous, active-low reset.
- REQ-007: m_araddr in 32, m_arvalid in 1, m_arready out 1: master read address channel.
- REQ-008: m_rdata out 64, m_rresp out 2, m_rvalid out 1, m_rready in 1: master read data channel.
- REQ-009: m_awaddr in 32, m_awvalid in 1, m_awready out 1: master write address channel.
- REQ-010: m_wdata in 64, m_wstrb in 8, m_wvalid in 1, m_wready out 1: master write data channel.
- REQ-011: m_bresp out 2, m_bvalid out 1, m_bready in 1: master write response channel.
- REQ-012: s0_* and s1_* SHALL each carry the same five channels with the same widths and mirrored directions (AXI-lite slave-side bundle).

Function
- REQ-013: Decode hits slave 0 iff (addr & MEM_MASK)==MEM_BASE, else slave 1 iff (addr & DEV_MASK)==DEV_BASE, else decode error; slave 0 wins if both match.
- REQ-014: FSM states: IDLE, RD, WR, RD_ERR, WR_ERR_W, WR_ERR_B; exactly one transaction in flight.
- REQ-015: m_arready = (state==IDLE); m_awready = (state==IDLE) & !m_arvalid; read wins when m_arvalid and m_awvalid are both high in IDLE.
- REQ-016: On AR handshake in IDLE: latch araddr and target; next state RD, or RD_ERR on decode error.
- REQ-017: On AW handshake in IDLE: latch awaddr and target; next state WR, or WR_ERR_W on decode error.
- REQ-018: In RD/WR, the selected slave's arvalid/awvalid is driven from an ar/aw pending flag set on entry and cleared on that slave's arready/awready; address comes from the latched register.
- REQ-019: In RD, selected slave R channel is forwarded combinationally to the master (rdata, rresp, rvalid, rready); on m_rvalid & m_rready, return to IDLE.
- REQ-020: In WR, W channel is passed through combinationally to the selected slave, and B channel is passed back; on m_bvalid & m_bready, return to IDLE.
- REQ-021: W data accepted before the slave's AW handshake SHALL be passed through unchanged (no reordering, no buffering).
- REQ-022: RD_ERR: m_rvalid=1, m_rdata=0, m_rresp=2'b11 until m_rready, then IDLE; no slave sees a request.
- REQ-023: WR_ERR_W: m_wready=1, W data discarded; on m_wvalid go to WR_ERR_B.
- REQ-024: WR_ERR_B: m_bvalid=1, m_bresp=2'b11 until m_bready, then IDLE.
- REQ-025: The unselected slave SHALL see arvalid, awvalid, wvalid, rready and bready all low, with address, data and strobe driven to 0.
- REQ-026: Master outputs not owned by the current state SHALL be 0.
- REQ-027: Minimum read latency is 3 cycles (AR accept, slave AR, slave R) with a zero-wait slave; back-to-back transactions need one IDLE cycle between them.

Reset
- REQ-028: While rst is low: state=IDLE, pending flags=0, latched address=0, and all valid and ready outputs=0 (except m_arready/m_awready, per REQ-015 after release).
- REQ-029: Reset asserted mid-transaction SHALL abort immediately with no response issued; the first cycle after release is IDLE.

Verification
- REQ-030: Read 0x8000_0010, s0 returns 64'h1122_3344_5566_7788, OKAY -> m_rdata matches, m_rresp=0, s1 untouched.
- REQ-031: Write 0xA000_03F8, wdata=0x41, wstrb=0x01 -> s1 sees the same addr/data/strb, s1 bresp=0 forwarded, s0 untouched.
- REQ-032: Read 0x1000_0000 -> m_rvalid with m_rresp=2'b11 and m_rdata=0; neither slave sees arvalid.
- REQ-033: arvalid and awvalid raised in the same cycle -> read completes first, then write is accepted after the IDLE cycle.
- REQ-034: s0 holds arready low for 5 cycles and rvalid with m_rready low for 3 cycles -> araddr stays stable and there is exactly one R handshake.
- REQ-035: Drop rst in RD state -> all valids 0 next cycle; after release, a fresh read completes normally.
